// File: rtl/lcd_nibble_driver_if.sv
// ----------------------------------------------------------------------------
// lcd_nibble_driver_if
//
// Byte handshake between the LCD controller FSM (master) and the nibble
// driver (slave).
//
// Signals:
//   enable      master -> slave  request to send one byte
//   data_in     master -> slave  byte to send, stable while enable=1
//   rs_in       master -> slave  0 = instruction, 1 = data write
//   driver_rdy  slave -> master  one-cycle pulse: byte sent and executed
//   busy        slave -> master  high from accept until the post-ready gap ends
// ----------------------------------------------------------------------------
interface lcd_nibble_driver_if;
  logic       enable;
  logic [7:0] data_in;
  logic       rs_in;
  logic       driver_rdy;
  logic       busy;

  modport master (
    output enable,
    output data_in,
    output rs_in,
    input  driver_rdy,
    input  busy
  );

  modport slave (
    input  enable,
    input  data_in,
    input  rs_in,
    output driver_rdy,
    output busy
  );
endinterface

// File: rtl/lcd_nibble_driver.sv
// ----------------------------------------------------------------------------
// lcd_nibble_driver
//
// Bus-level driver for an HD44780-compatible LCD (1602A) in 4-bit mode.
// Accepts one byte per enable/driver_rdy handshake, sends it as a high nibble
// followed by a low nibble with setup / E-pulse / hold timing, waits for the
// LCD execution time, then pulses driver_rdy.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   bus      lcd_nibble_driver_if.slave (enable, data_in, rs_in,
//            driver_rdy, busy)
//   lcd_rs   LCD register select
//   lcd_rw   LCD read/write, always 0 (write-only)
//   lcd_e    LCD enable strobe
//   lcd_db   LCD DB[7:4]
//
// Optional feature (macro LCD_POWERUP_INIT_EN): after reset, run the
// HD44780 4-bit wake-up sequence (power wait, nibbles 3,3,3,2) before the
// first byte is accepted. Without the macro, reset goes straight to IDLE.
// ----------------------------------------------------------------------------
module lcd_nibble_driver #(
  parameter int T_AS        = 2,
  parameter int T_PW        = 13,
  parameter int T_H         = 1,
  parameter int T_NIB       = 50,
  parameter int T_EXEC      = 2100,
  parameter int T_EXEC_LONG = 82000,
  parameter int T_GAP       = 2
`ifdef LCD_POWERUP_INIT_EN
  ,
  parameter int T_PWR       = 750000,
  parameter int T_WAKE1     = 205000,
  parameter int T_WAKE2     = 5000
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  lcd_nibble_driver_if.slave        bus,
  output logic                      lcd_rs,
  output logic                      lcd_rw,
  output logic                      lcd_e,
  output logic [3:0]                lcd_db
);

  // Counter reload values: a timed state lasting T cycles starts at T-1.
  localparam logic [19:0] C_AS   = 20'(T_AS - 1);
  localparam logic [19:0] C_PW   = 20'(T_PW - 1);
  localparam logic [19:0] C_H    = 20'(T_H - 1);
  localparam logic [19:0] C_NIB  = 20'(T_NIB - 1);
  localparam logic [19:0] C_EXEC = 20'(T_EXEC - 1);
  localparam logic [19:0] C_LONG = 20'(T_EXEC_LONG - 1);
  localparam logic [19:0] C_GAP  = 20'(T_GAP - 1);
`ifdef LCD_POWERUP_INIT_EN
  localparam logic [19:0] C_PWR   = 20'(T_PWR - 1);
  localparam logic [19:0] C_WAKE1 = 20'(T_WAKE1 - 1);
  localparam logic [19:0] C_WAKE2 = 20'(T_WAKE2 - 1);
`endif

  typedef enum logic [3:0] {
    IDLE,
    HI_AS,
    HI_PW,
    HI_H,
    NIB_GAP,
    LO_AS,
    LO_PW,
    LO_H,
    EXEC,
    DONE,
    GAP
`ifdef LCD_POWERUP_INIT_EN
    ,
    PWR_WAIT,
    W_AS,
    W_PW,
    W_H,
    W_WAIT
`endif
  } state_t;

  state_t      state;
  logic [19:0] cnt;
  logic [7:0]  byte_r;
  logic        rs_r;
  logic        cnt_zero;
  logic        is_long;

`ifdef LCD_POWERUP_INIT_EN
  logic [1:0]  wake_idx;
  logic [19:0] wake_wait;
`endif

  assign cnt_zero = (cnt == 20'd0);

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  assign is_long = !rs_r && (byte_r[7:2] == 6'd0) && (byte_r[1:0] != 2'd0);

`ifdef LCD_POWERUP_INIT_EN
  // Wait after each wake-up nibble: 4.1 ms, 100 us, then normal execution time.
  always_comb begin
    wake_wait = C_EXEC;
    case (wake_idx)
      2'd0:    wake_wait = C_WAKE1;
      2'd1:    wake_wait = C_WAKE2;
      default: wake_wait = C_EXEC;
    endcase
  end
`endif

  // Single FSM with registered outputs. Outputs are assigned on the edge that
  // enters a state, so lcd_db/lcd_rs are set on entry to the setup states and
  // only lcd_e moves on the setup->pulse and pulse->hold transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_e          <= 1'b0;
      lcd_rs         <= 1'b0;
      lcd_rw         <= 1'b0;
      lcd_db         <= 4'h0;
      bus.driver_rdy <= 1'b0;
      byte_r         <= 8'h00;
      rs_r           <= 1'b0;
`ifdef LCD_POWERUP_INIT_EN
      state          <= PWR_WAIT;
      cnt            <= C_PWR;
      bus.busy       <= 1'b1;
      wake_idx       <= 2'd0;
`else
      state          <= IDLE;
      cnt            <= 20'd0;
      bus.busy       <= 1'b0;
`endif
    end else begin
      lcd_rw         <= 1'b0;
      bus.driver_rdy <= 1'b0;
      if (!cnt_zero) begin
        cnt <= cnt - 20'd1;
      end

      case (state)
        IDLE: begin
          lcd_e <= 1'b0;
          if (bus.enable) begin
            byte_r   <= bus.data_in;
            rs_r     <= bus.rs_in;
            lcd_rs   <= bus.rs_in;
            lcd_db   <= bus.data_in[7:4];
            bus.busy <= 1'b1;
            cnt      <= C_AS;
            state    <= HI_AS;
          end
        end

        HI_AS: if (cnt_zero) begin
          lcd_e <= 1'b1;
          cnt   <= C_PW;
          state <= HI_PW;
        end

        HI_PW: if (cnt_zero) begin
          lcd_e <= 1'b0;
          cnt   <= C_H;
          state <= HI_H;
        end

        HI_H: if (cnt_zero) begin
          cnt   <= C_NIB;
          state <= NIB_GAP;
        end

        NIB_GAP: if (cnt_zero) begin
          lcd_db <= byte_r[3:0];
          cnt    <= C_AS;
          state  <= LO_AS;
        end

        LO_AS: if (cnt_zero) begin
          lcd_e <= 1'b1;
          cnt   <= C_PW;
          state <= LO_PW;
        end

        LO_PW: if (cnt_zero) begin
          lcd_e <= 1'b0;
          cnt   <= C_H;
          state <= LO_H;
        end

        LO_H: if (cnt_zero) begin
          cnt   <= is_long ? C_LONG : C_EXEC;
          state <= EXEC;
        end

        EXEC: if (cnt_zero) begin
          bus.driver_rdy <= 1'b1;
          state          <= DONE;
        end

        // DONE is a single cycle; GAP then masks enable while the controller
        // catches up with the ready pulse.
        DONE: begin
          cnt   <= C_GAP;
          state <= GAP;
        end

        GAP: if (cnt_zero) begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

`ifdef LCD_POWERUP_INIT_EN
        PWR_WAIT: if (cnt_zero) begin
          lcd_rs <= 1'b0;
          lcd_db <= 4'h3;
          cnt    <= C_AS;
          state  <= W_AS;
        end

        W_AS: if (cnt_zero) begin
          lcd_e <= 1'b1;
          cnt   <= C_PW;
          state <= W_PW;
        end

        W_PW: if (cnt_zero) begin
          lcd_e <= 1'b0;
          cnt   <= C_H;
          state <= W_H;
        end

        W_H: if (cnt_zero) begin
          cnt   <= wake_wait;
          state <= W_WAIT;
        end

        // Nibble sequence is 3,3,3,2; the fourth wait ends the wake-up.
        W_WAIT: if (cnt_zero) begin
          if (wake_idx == 2'd3) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            lcd_db   <= (wake_idx == 2'd2) ? 4'h2 : 4'h3;
            wake_idx <= wake_idx + 2'd1;
            cnt      <= C_AS;
            state    <= W_AS;
          end
        end
`endif

        default: begin
          lcd_e <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_nibble_driver.sv
// ----------------------------------------------------------------------------
// tb_lcd_nibble_driver
//
// Self-checking bench for lcd_nibble_driver. A behavioural model tracks each
// accepted byte as "cycles since accept" and derives the expected pin
// waveform from the timing parameters; a compare process checks the DUT
// every cycle. Directed sequences pin the model with literal values, then
// randomized enable/data/rs traffic (with occasional resets) runs against it.
// Build with +define+LCD_POWERUP_INIT_EN to also cover the wake-up sequence.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_nibble_driver;

  localparam int T_AS        = 2;
  localparam int T_PW        = 4;
  localparam int T_H         = 1;
  localparam int T_NIB       = 3;
  localparam int T_EXEC      = 10;
  localparam int T_EXEC_LONG = 40;
  localparam int T_GAP       = 2;
  localparam int NIB_LEN     = T_AS + T_PW + T_H;
`ifdef LCD_POWERUP_INIT_EN
  localparam int T_PWR       = 20;
  localparam int T_WAKE1     = 8;
  localparam int T_WAKE2     = 4;
  localparam bit INIT_EN     = 1'b1;
  int wake_wait [4] = '{T_WAKE1, T_WAKE2, T_EXEC, T_EXEC};
  int wake_nib  [4] = '{3, 3, 3, 2};
`else
  localparam bit INIT_EN     = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [3:0] lcd_db;

  lcd_nibble_driver_if bus();

  lcd_nibble_driver #(
    .T_AS        (T_AS),
    .T_PW        (T_PW),
    .T_H         (T_H),
    .T_NIB       (T_NIB),
    .T_EXEC      (T_EXEC),
    .T_EXEC_LONG (T_EXEC_LONG),
    .T_GAP       (T_GAP)
`ifdef LCD_POWERUP_INIT_EN
    ,
    .T_PWR       (T_PWR),
    .T_WAKE1     (T_WAKE1),
    .T_WAKE2     (T_WAKE2)
`endif
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .lcd_rs (lcd_rs),
    .lcd_rw (lcd_rw),
    .lcd_e  (lcd_e),
    .lcd_db (lcd_db)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state
  bit         check_en = 1'b0;
  bit         m_active = 1'b0;
  bit         m_init   = 1'b0;
  int         m_k      = 0;
  int         m_end    = 0;
  logic [7:0] m_byte   = 8'h00;
  logic       m_rs     = 1'b0;

  // Observation log
  logic [31:0] pulse_db [$];
  logic [31:0] pulse_rs [$];
  logic [31:0] pulse_w  [$];
  int          rise_cyc [$];
  int          acc_cyc  = 0;
  int          rdy_cyc  = 0;
  int          rdy_cnt  = 0;
  int          cur_w    = 0;
  logic        prev_e   = 1'b0;
  logic        prev_busy = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] data, input logic rs);
    bus.enable  = en;
    bus.data_in = data;
    bus.rs_in   = rs;
  endtask

  function automatic logic [31:0] qAt(input logic [31:0] q [$], input int i);
    if (i < q.size()) return q[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic int execLen(input logic [7:0] b, input logic r);
    // clear display / return home
    if (!r && b >= 8'h01 && b <= 8'h03) return T_EXEC_LONG;
    return T_EXEC;
  endfunction

  function automatic int initLen();
    int s = 0;
`ifdef LCD_POWERUP_INIT_EN
    s = T_PWR;
    for (int i = 0; i < 4; i++) s += NIB_LEN + wake_wait[i];
`endif
    return s;
  endfunction

  // Behavioural model: position inside the current transaction.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      check_en = 1'b1;
      m_k      = 0;
      m_active = INIT_EN;
      m_init   = INIT_EN;
      m_end    = initLen();
    end else if (m_active) begin
      m_k++;
      if (m_k == m_end) m_active = 1'b0;
    end else if (bus.enable) begin
      m_active = 1'b1;
      m_init   = 1'b0;
      m_k      = 0;
      m_byte   = bus.data_in;
      m_rs     = bus.rs_in;
      m_end    = 2 * NIB_LEN + T_NIB + execLen(bus.data_in, bus.rs_in) + T_GAP + 1;
    end
  end

  // Compare process plus observation log.
  always @(negedge clk) begin : cmp
    logic       exp_e, exp_rdy, exp_busy, exp_rs, db_chk;
    logic [3:0] exp_db;
    int         lo, len;
    if (check_en) begin
      exp_e = 1'b0; exp_rdy = 1'b0; exp_busy = 1'b0; exp_rs = 1'b0;
      db_chk = 1'b0; exp_db = 4'h0;
      lo = NIB_LEN + T_NIB;
      if (m_active) begin
        exp_busy = 1'b1;
        if (m_init) begin
`ifdef LCD_POWERUP_INIT_EN
          int s;
          s = T_PWR;
          for (int i = 0; i < 4; i++) begin
            if (m_k >= s && m_k < s + NIB_LEN) begin
              db_chk = 1'b1;
              exp_db = 4'(wake_nib[i]);
            end
            if (m_k >= s + T_AS && m_k < s + T_AS + T_PW) exp_e = 1'b1;
            s += NIB_LEN + wake_wait[i];
          end
`endif
        end else begin
          len    = 2 * NIB_LEN + T_NIB + execLen(m_byte, m_rs);
          exp_rs = m_rs;
          if (m_k < NIB_LEN) begin
            db_chk = 1'b1;
            exp_db = m_byte[7:4];
          end
          if (m_k >= lo && m_k < lo + NIB_LEN) begin
            db_chk = 1'b1;
            exp_db = m_byte[3:0];
          end
          exp_e   = (m_k >= T_AS && m_k < T_AS + T_PW) ||
                    (m_k >= lo + T_AS && m_k < lo + T_AS + T_PW);
          exp_rdy = (m_k == len);
        end
      end
      checkOutput("lcd_e", lcd_e, exp_e);
      checkOutput("driver_rdy", bus.driver_rdy, exp_rdy);
      checkOutput("busy", bus.busy, exp_busy);
      checkOutput("lcd_rw", lcd_rw, 0);
      if (db_chk) begin
        checkOutput("lcd_db", lcd_db, exp_db);
        checkOutput("lcd_rs", lcd_rs, exp_rs);
      end
    end

    if (lcd_e === 1'b1 && prev_e !== 1'b1) begin
      pulse_db.push_back(32'(lcd_db));
      pulse_rs.push_back(32'(lcd_rs));
      rise_cyc.push_back(cyc);
      cur_w = 0;
    end
    if (lcd_e === 1'b1) cur_w++;
    if (lcd_e !== 1'b1 && prev_e === 1'b1) pulse_w.push_back(32'(cur_w));
    if (bus.busy === 1'b1 && prev_busy !== 1'b1) acc_cyc = cyc;
    if (bus.driver_rdy === 1'b1) begin
      rdy_cyc = cyc;
      rdy_cnt++;
    end
    prev_e    = lcd_e;
    prev_busy = bus.busy;
  end

  task automatic clearLog();
    pulse_db.delete();
    pulse_rs.delete();
    pulse_w.delete();
    rise_cyc.delete();
    rdy_cnt = 0;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic waitRdy(input int limit, input string tag);
    int start = rdy_cnt;
    int n = 0;
    while (rdy_cnt == start && n < limit) begin
      stepCycle();
      n++;
    end
    n_checks++;
    if (rdy_cnt == start) begin
      n_fail++;
      $display("[TB] FAIL %s_timeout: got no driver_rdy, expected one within %0d cycles", tag, limit);
    end
  endtask

  task automatic waitIdle(input int limit, input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < limit) begin
      stepCycle();
      n++;
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL %s_idle_timeout: got busy=%b, expected 0 within %0d cycles", tag, bus.busy, limit);
    end
  endtask

  task automatic sendByte(input logic [7:0] data, input logic rs);
    waitIdle(300, "send");
    clearLog();
    applyStimulus(1'b1, data, rs);
    stepCycle();
    bus.enable = 1'b0;
  endtask

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 60000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int n;
    applyStimulus(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;

    // Reset state
    checkOutput("rst_lcd_e", lcd_e, 0);
    checkOutput("rst_lcd_rs", lcd_rs, 0);
    checkOutput("rst_lcd_rw", lcd_rw, 0);
    checkOutput("rst_lcd_db", lcd_db, 0);
    checkOutput("rst_rdy", bus.driver_rdy, 0);
    checkOutput("rst_busy", bus.busy, INIT_EN);

`ifdef LCD_POWERUP_INIT_EN
    // Wake-up sequence with enable held high: it must be ignored.
    begin
      int rst_cyc;
      clearLog();
      applyStimulus(1'b1, 8'h28, 1'b0);
      rst_cyc = cyc;
      rst = 1'b0;
      waitIdle(300, "init");
      bus.enable = 1'b0;
      checkOutput("init_npulse", pulse_db.size(), 4);
      checkOutput("init_nib0", qAt(pulse_db, 0), 3);
      checkOutput("init_nib1", qAt(pulse_db, 1), 3);
      checkOutput("init_nib2", qAt(pulse_db, 2), 3);
      checkOutput("init_nib3", qAt(pulse_db, 3), 2);
      checkOutput("init_w0", qAt(pulse_w, 0), 4);
      // first rise: 20 power cycles + 2 setup
      checkOutput("init_first_rise", (rise_cyc.size() > 0) ? rise_cyc[0] - rst_cyc : -1, 22);
      // rise-to-rise: 4 pulse + 1 hold + wait + 2 setup
      checkOutput("init_gap1", (rise_cyc.size() > 1) ? rise_cyc[1] - rise_cyc[0] : -1, 15);
      checkOutput("init_gap2", (rise_cyc.size() > 2) ? rise_cyc[2] - rise_cyc[1] : -1, 11);
      checkOutput("init_gap3", (rise_cyc.size() > 3) ? rise_cyc[3] - rise_cyc[2] : -1, 17);
      checkOutput("init_no_rdy", rdy_cnt, 0);
    end
`else
    rst = 1'b0;
`endif

    // 0x28 as instruction, enable held high into the next byte
    waitIdle(300, "a");
    clearLog();
    applyStimulus(1'b1, 8'h28, 1'b0);
    waitRdy(100, "a");
    checkOutput("a_npulse", pulse_db.size(), 2);
    checkOutput("a_db_hi", qAt(pulse_db, 0), 4'h2);
    checkOutput("a_db_lo", qAt(pulse_db, 1), 4'h8);
    checkOutput("a_w_hi", qAt(pulse_w, 0), 4);
    checkOutput("a_w_lo", qAt(pulse_w, 1), 4);
    checkOutput("a_rs_hi", qAt(pulse_rs, 0), 0);
    checkOutput("a_latency", rdy_cyc - acc_cyc, 27);

    // Back-to-back: new byte presented the cycle after driver_rdy
    stepCycle();
    clearLog();
    bus.data_in = 8'h06;
    waitRdy(100, "c");
    bus.enable = 1'b0;
    checkOutput("c_npulse", pulse_db.size(), 2);
    checkOutput("c_db_hi", qAt(pulse_db, 0), 4'h0);
    checkOutput("c_db_lo", qAt(pulse_db, 1), 4'h6);
    checkOutput("c_latency", rdy_cyc - acc_cyc, 27);

    // Clear display uses the long execution wait
    sendByte(8'h01, 1'b0);
    waitRdy(200, "b1");
    checkOutput("b1_latency", rdy_cyc - acc_cyc, 57);

    // Data write 0x41
    sendByte(8'h41, 1'b1);
    waitRdy(100, "b2");
    checkOutput("b2_latency", rdy_cyc - acc_cyc, 27);
    checkOutput("b2_rs_hi", qAt(pulse_rs, 0), 1);
    checkOutput("b2_rs_lo", qAt(pulse_rs, 1), 1);
    checkOutput("b2_db_hi", qAt(pulse_db, 0), 4'h4);
    checkOutput("b2_db_lo", qAt(pulse_db, 1), 4'h1);

    // Reset during the second HI_PW cycle
    sendByte(8'h33, 1'b0);
    n = 0;
    while (lcd_e !== 1'b1 && n < 50) begin
      stepCycle();
      n++;
    end
    stepCycle();
    rst = 1'b1;
    stepCycle();
    checkOutput("d_rst_e", lcd_e, 0);
    checkOutput("d_rst_busy", bus.busy, INIT_EN);
    checkOutput("d_rst_rdy", bus.driver_rdy, 0);
    rst = 1'b0;
    sendByte(8'h0C, 1'b0);
    waitRdy(100, "d");
    checkOutput("d_db_hi", qAt(pulse_db, 0), 4'h0);
    checkOutput("d_db_lo", qAt(pulse_db, 1), 4'hC);
    checkOutput("d_latency", rdy_cyc - acc_cyc, 27);

    // data_in scribbled during the low-nibble pulse
    sendByte(8'h5A, 1'b1);
    n = 0;
    while (pulse_db.size() < 2 && n < 50) begin
      stepCycle();
      n++;
    end
    applyStimulus(1'b0, 8'hFF, 1'b0);
    stepCycle();
    checkOutput("e_lo_db", lcd_db, 4'hA);
    checkOutput("e_lo_rs", lcd_rs, 1);
    waitRdy(100, "e");
    checkOutput("e_latency", rdy_cyc - acc_cyc, 27);

    // Randomized traffic with rare resets
    waitIdle(300, "rand");
    clearLog();
    for (int i = 0; i < 3000; i++) begin
      stepCycle();
      rst        = ($urandom_range(0, 499) == 0);
      bus.enable = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.data_in = 8'($urandom_range(1, 3));
        bus.rs_in   = 1'b0;
      end else begin
        bus.data_in = 8'($urandom);
        bus.rs_in   = 1'($urandom);
      end
    end
    stepCycle();
    rst        = 1'b0;
    bus.enable = 1'b0;
    n_checks++;
    if (rdy_cnt == 0) begin
      n_fail++;
      $display("[TB] FAIL rand_rdy_count: got 0 ready pulses, expected at least 1");
    end
    waitIdle(300, "end");
    repeat (3) stepCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
